// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data memory unit: access sizes,
// FSM states, legality, byte-enable/store-lane alignment and load extension.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  function automatic logic is_legal(input size_e sz, input logic [1:0] off);
    logic ok;
    unique case (sz)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      SZ_WORD: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
    logic [3:0] m;
    unique case (sz)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = 4'b0011 << off;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate the right-aligned store data so every candidate lane sees it;
  // the byte enables then pick the lanes that actually get written.
  function automatic logic [31:0] store_lanes(input size_e sz, input logic [31:0] d);
    logic [31:0] v;
    unique case (sz)
      SZ_BYTE: v = {4{d[7:0]}};
      SZ_HALF: v = {2{d[15:0]}};
      default: v = d;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input size_e sz,
                                              input logic [1:0] off, input logic sx);
    logic [31:0] sh;
    logic [31:0] v;
    sh = word >> {off, 3'b000};
    unique case (sz)
      SZ_BYTE: v = {{24{sx & sh[7]}}, sh[7:0]};
      SZ_HALF: v = {{16{sx & sh[15]}}, sh[15:0]};
      default: v = word;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dmem_ram #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: the array has no reset on purpose; contents survive rst and a reset
  // branch here would stop the storage mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/data_mem_unit.sv
// Load/store data memory front end: checks alignment, writes stores in one
// cycle, and returns extended load data one cycle after the request.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        misalign
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e      state;
  size_e       sz;
  size_e       size_q;
  logic [1:0]  off;
  logic [1:0]  off_q;
  logic        sx_q;
  logic        legal;
  logic        accept;
  logic        rvalid_q;
  logic        misalign_q;
  logic [31:0] rdata_q;
  logic [31:0] ram_q;
  logic [31:0] load_data;
  logic        unused_addr_bits;

  assign sz     = size_e'(size);
  assign off    = addr[1:0];
  assign legal  = is_legal(sz, off);
  // rst gates the RAM port directly so a request in a reset cycle never writes.
  assign accept = (state == IDLE) && req && legal && !rst;

  // Upper address bits are don't-care: addresses wrap modulo the RAM size.
  assign unused_addr_bits = ^addr[31:AW+2];

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .en    (accept),
    .we    (we),
    .be    (lane_mask(sz, off)),
    .idx   (addr[AW+1:2]),
    .wdata (store_lanes(sz, wdata)),
    .rdata (ram_q)
  );

  assign load_data = load_extend(ram_q, size_q, off_q, sx_q);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      rdata_q    <= '0;
      size_q     <= SZ_BYTE;
      off_q      <= 2'b00;
      sx_q       <= 1'b0;
    end else begin
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req && !legal) begin
            misalign_q <= 1'b1;
          end else if (req && !we) begin
            size_q   <= sz;
            off_q    <= off;
            sx_q     <= sign_ext;
            rvalid_q <= 1'b1;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          rdata_q <= load_data;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The RAM's registered read lands during RD_WAIT, so the live value is shown
  // then and the holding register covers every other cycle.
  assign ready    = (state == IDLE);
  assign rvalid   = rvalid_q;
  assign misalign = misalign_q;
  assign rdata    = rvalid_q ? load_data : rdata_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: directed scenarios plus random
// load/store/illegal traffic against a byte-array reference model.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        misalign;

  logic [7:0]  model_mem [1024];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  data_mem_unit #(.DEPTH_WORDS(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .misalign (misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model: 1 KiB of bytes, little-endian, address mod 1024 ----
  function automatic bit model_legal(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'd0) || (s == 2'd1 && a % 2 == 0) || (s == 2'd2 && a % 4 == 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s,
                                             input logic sx);
    logic [31:0] v = '0;
    int base = int'(a % 1024);
    for (int i = 0; i < (1 << s); i++) v[8*i +: 8] = model_mem[base + i];
    if (sx && s == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (sx && s == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int base = int'(a % 1024);
    for (int i = 0; i < (1 << s); i++) model_mem[base + i] = d[8*i +: 8];
  endtask

  // ---- bus helpers: drive after #1, sample #1 after the edge ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] s, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    req = r; we = w; size = s; sign_ext = sx; addr = a; wdata = d;
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s);
    drive(1'b1, 1'b1, s, 1'b0, a, d);
    step();
    req = 1'b0;
    check({tag, " st rvalid"}, {31'b0, rvalid}, 32'd0);
    check({tag, " st misalign"}, {31'b0, misalign}, 32'd0);
    check({tag, " st ready"}, {31'b0, ready}, 32'd1);
    model_store(a, d, s);
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] s,
                         input logic sx);
    logic [31:0] exp;
    exp = model_load(a, s, sx);
    drive(1'b1, 1'b0, s, sx, a, 32'h0);
    step();
    req = 1'b0;
    check({tag, " ld rvalid"}, {31'b0, rvalid}, 32'd1);
    check({tag, " ld ready"}, {31'b0, ready}, 32'd0);
    check({tag, " ld rdata"}, rdata, exp);
    step();
    check({tag, " ld rvalid drop"}, {31'b0, rvalid}, 32'd0);
    check({tag, " ld ready back"}, {31'b0, ready}, 32'd1);
    check({tag, " ld rdata hold"}, rdata, exp);
  endtask

  task automatic do_illegal(input string tag, input logic [31:0] a, input logic [1:0] s,
                            input logic w, input logic [31:0] d);
    drive(1'b1, w, s, 1'b0, a, d);
    step();
    req = 1'b0;
    check({tag, " misalign"}, {31'b0, misalign}, 32'd1);
    check({tag, " rvalid"}, {31'b0, rvalid}, 32'd0);
    check({tag, " ready"}, {31'b0, ready}, 32'd1);
    step();
    check({tag, " misalign drop"}, {31'b0, misalign}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
    logic        w;
    logic        sx;

    rst = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    step();
    check("reset ready", {31'b0, ready}, 32'd1);
    check("reset rvalid", {31'b0, rvalid}, 32'd0);
    check("reset misalign", {31'b0, misalign}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    step();
    rst = 1'b0;

    // Give every word a known value so the model covers the whole RAM.
    for (int i = 0; i < 256; i++) do_store("preload", 32'(i * 4), $urandom(), 2'd2);

    do_store("sw_lw", 32'h10, 32'hDEAD_BEEF, 2'd2);
    do_load("sw_lw", 32'h10, 2'd2, 1'b0);

    do_store("sb", 32'h10, 32'h1122_3344, 2'd2);
    do_store("sb", 32'h13, 32'h0000_00A5, 2'd0);
    do_load("lb_sx", 32'h13, 2'd0, 1'b1);
    do_load("lb_zx", 32'h13, 2'd0, 1'b0);
    do_load("lw_after_sb", 32'h10, 2'd2, 1'b0);

    do_store("half", 32'h10, 32'h8001_FFFF, 2'd2);
    do_load("lhu", 32'h12, 2'd1, 1'b0);
    do_load("lh", 32'h12, 2'd1, 1'b1);
    do_load("lh_lo", 32'h10, 2'd1, 1'b1);
    do_store("sh", 32'h12, 32'hABCD_1234, 2'd1);
    do_load("lw_after_sh", 32'h10, 2'd2, 1'b0);

    do_store("mis", 32'h04, 32'h0BAD_CAFE, 2'd2);
    do_illegal("sw_0x06", 32'h06, 2'd2, 1'b1, 32'hFFFF_FFFF);
    do_illegal("sz11_st", 32'h04, 2'd3, 1'b1, 32'h1234_5678);
    do_illegal("sh_odd", 32'h05, 2'd1, 1'b1, 32'h0000_7777);
    do_illegal("lw_odd", 32'h07, 2'd2, 1'b0, 32'h0);
    do_load("mis_nowrite", 32'h04, 2'd2, 1'b0);

    // Reset while a load sits in RD_WAIT.
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    step();
    req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_rdwait rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_rdwait rdata", rdata, 32'd0);
    check("rst_rdwait ready", {31'b0, ready}, 32'd1);
    step();
    check("rst_rdwait no late rvalid", {31'b0, rvalid}, 32'd0);

    // A store presented together with reset must not write.
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h20, ~model_load(32'h20, 2'd2, 1'b0));
    step();
    rst = 1'b0;
    req = 1'b0;
    check("rst_store ready", {31'b0, ready}, 32'd1);
    do_load("rst_store nowrite", 32'h20, 2'd2, 1'b0);

    // Requests held during RD_WAIT are ignored: no write, no misalign.
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    step();
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h11, 32'hCAFE_F00D);
    check("rdwait_hold rvalid", {31'b0, rvalid}, 32'd1);
    check("rdwait_hold rdata", rdata, model_load(32'h10, 2'd2, 1'b0));
    step();
    req = 1'b0;
    check("rdwait_hold misalign", {31'b0, misalign}, 32'd0);
    check("rdwait_hold ready", {31'b0, ready}, 32'd1);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    step();
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h14, 32'h5555_AAAA);
    step();
    req = 1'b0;
    check("rdwait_store misalign", {31'b0, misalign}, 32'd0);
    do_load("rdwait_store nowrite", 32'h14, 2'd2, 1'b0);
    do_load("rdwait_ill nowrite", 32'h10, 2'd2, 1'b0);

    do_store("wrap", 32'h400, 32'h0000_0005, 2'd2);
    do_load("wrap", 32'h000, 2'd2, 1'b0);

    for (int i = 0; i < 400; i++) begin
      a  = $urandom();
      d  = $urandom();
      s  = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      // Bias toward legal addresses so most traffic exercises the datapath.
      if ($urandom_range(0, 3) != 0) a[1:0] = a[1:0] & ~((2'(1) << s) - 2'd1);
      if (!model_legal(s, a))  do_illegal("rnd_ill", a, s, w, d);
      else if (w)              do_store("rnd", a, d, s);
      else                     do_load("rnd", a, s, sx);
    end

    for (int i = 0; i < 16; i++) do_load("final_sweep", 32'(i * 64), 2'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
